// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared state encoding and default bit timing for the UART
//                transmitter and its bit timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter; pulses bit_done on the last
//                cycle of each CLKS_PER_BIT-long bit while run is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_done
);

    localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holding the count at zero while stopped makes the first bit after run
    // rises exactly CLKS_PER_BIT cycles long.
    always_comb begin
        count_d  = count_q;
        bit_done = 1'b0;
        if (!run) begin
            count_d = '0;
        end else if (count_q == CNT_LAST) begin
            count_d  = '0;
            bit_done = 1'b1;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : 8N1 UART transmitter that pops bytes straight from a FIFO
//                read port (one-cycle read latency) and serialises them LSB
//                first.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state_q;
    tx_state_e  state_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_idx_q;
    logic [2:0] bit_idx_d;
    logic       tx_q;
    logic       tx_d;
    logic       bit_run;
    logic       bit_done;

    assign bit_run = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (bit_run),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            // fifo_dout is valid here, one cycle after the pop.
            ST_LOAD: begin
                shift_d   = fifo_dout;
                bit_idx_d = '0;
                tx_d      = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d      = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    assign fifo_rd_en = (state_q == ST_FETCH);
    assign busy       = (state_q != ST_IDLE);
    assign tx         = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx with a behavioural FIFO
//                and a frame-level reference model of the serial line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB    = 4;
    localparam int FRAME  = 10 * CPB;
    localparam int PERIOD = FRAME + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    // Behavioural FIFO: data appears on fifo_dout the cycle after the pop.
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
            pops      <= pops + 1;
        end
    end

    // One history entry per rising edge, holding the values after that edge.
    logic tx_h[$];
    logic busy_h[$];
    logic rd_h[$];
    always begin
        @(posedge clk);
        #1;
        tx_h.push_back(tx);
        busy_h.push_back(busy);
        rd_h.push_back(fifo_rd_en);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: the byte becomes visible at the next rising edge,
    // whose history index is returned in e.
    task automatic push_now(input logic [7:0] d, output int e);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
        e = tx_h.size();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idx(input int idx);
        int guard = 0;
        while (tx_h.size() <= idx && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (tx_h.size() <= idx) chk("timeout", tx_h.size(), idx + 1);
    endtask

    function automatic int count_ones(input int kind, input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) begin
            if (kind == 0 && tx_h[i])   n++;
            if (kind == 1 && busy_h[i]) n++;
            if (kind == 2 && rd_h[i])   n++;
        end
        return n;
    endfunction

    // Serial line level in bit slot k of an 8N1 frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return d[slot-1];
    endfunction

    task automatic check_frame(input int s, input logic [7:0] d);
        chk($sformatf("idle_before_%02h", d), int'(tx_h[s-1]), 1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                chk($sformatf("frame_%02h_slot%0d_c%0d", d, k, j),
                    int'(tx_h[s + k*CPB + j]), int'(exp_bit(d, k)));
            end
        end
    endtask

    typedef struct {
        logic rst;
        logic en;
        logic push;
        logic exp_tx;
        logic exp_busy;
        logic exp_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int e;
        int e2;
        int a;
        int p0;
        int n_rand;
        int s_prev;
        int s_last;
        int ev[$];
        int sv[$];
        logic [7:0] dv[$];

        // ---------------- table: reset, gating, abort, restart -------------
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            reset  = tbl[i].rst;
            enable = tbl[i].en;
            if (tbl[i].push) push_now((i == 0) ? 8'h3C : 8'hC3, e);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_tx", i),   int'(tx),         int'(tbl[i].exp_tx));
            chk($sformatf("tbl%0d_busy", i), int'(busy),       int'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_rd", i),   int'(fifo_rd_en), int'(tbl[i].exp_rd));
        end
        chk("tbl_pops", pops, 2);

        // ---------------- single byte 8'hA5 --------------------------------
        @(negedge clk);
        push_now(8'hA5, e);
        wait_idx(e + FRAME + 10);
        chk("a5_rd_at_fetch", int'(rd_h[e]), 1);
        chk("a5_rd_pulses", count_ones(2, e - 1, e + FRAME + 10), 1);
        check_frame(e + 2, 8'hA5);
        // FETCH + LOAD + the 10-bit frame
        chk("a5_busy_cycles", count_ones(1, e - 1, e + FRAME + 10), FRAME + 2);
        chk("a5_busy_before", int'(busy_h[e - 1]), 0);
        chk("a5_busy_after", int'(busy_h[e + FRAME + 2]), 0);

        // ---------------- reset mid-DATA -----------------------------------
        @(negedge clk);
        push_now(8'h5A, e);
        push_now(8'h96, e);
        @(negedge clk);
        enable = 1'b0;
        wait_idx(e + 2 + 3*CPB);
        @(negedge clk);
        p0 = pops;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(fifo_rd_en), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        a = tx_h.size();
        cycles(100);
        chk("rst_no_repop", pops, p0);
        chk("rst_tx_idle", count_ones(0, a, a + 100), 100);
        enable = 1'b1;
        e2 = tx_h.size();
        wait_idx(e2 + FRAME + 5);
        check_frame(e2 + 2, 8'h96);
        chk("rst_next_pop", pops, p0 + 1);

        // ---------------- enable gating ------------------------------------
        @(negedge clk);
        enable = 1'b0;
        push_now(8'h11, e);
        push_now(8'h22, e);
        a = tx_h.size();
        cycles(50);
        chk("gate_no_pop", count_ones(2, a, a + 50), 0);
        chk("gate_tx_idle", count_ones(0, a, a + 50), 50);
        enable = 1'b1;
        e = tx_h.size();
        @(negedge clk);
        enable = 1'b0;
        cycles(FRAME + 60);
        check_frame(e + 2, 8'h11);
        chk("gate_one_pop", count_ones(2, e, e + FRAME + 60), 1);
        chk("gate_22_queued", int'(fifo_empty), 0);
        enable = 1'b1;
        e2 = tx_h.size();
        wait_idx(e2 + FRAME + 5);
        check_frame(e2 + 2, 8'h22);

        // ---------------- back-to-back FF..F0 ------------------------------
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push_now(8'(8'hFF - i), e);
        @(negedge clk);
        enable = 1'b1;
        e = tx_h.size();
        wait_idx(e + 16*PERIOD + 10);
        for (int i = 0; i < 16; i++) check_frame(e + 2 + i*PERIOD, 8'(8'hFF - i));
        chk("b2b_pulses", count_ones(2, e, e + 16*PERIOD + 10), 16);
        chk("b2b_empty", int'(fifo_empty), 1);

        // ---------------- empty FIFO with enable high ----------------------
        @(negedge clk);
        a = tx_h.size();
        cycles(100);
        chk("empty_no_pop", count_ones(2, a, a + 100), 0);
        chk("empty_tx_idle", count_ones(0, a, a + 100), 100);

        // ---------------- randomized pushes vs frame-level model -----------
        // Each frame starts 2 cycles after its byte is visible, but no sooner
        // than one full frame plus 3 cycles after the previous start.
        n_rand = 24;
        s_prev = -100000;
        for (int n = 0; n < n_rand; n++) begin
            cycles($urandom_range(0, 60));
            dv.push_back(8'($urandom));
            push_now(dv[n], e);
            ev.push_back(e);
            s_prev = (e + 2 > s_prev + PERIOD) ? e + 2 : s_prev + PERIOD;
            sv.push_back(s_prev);
        end
        s_last = sv[n_rand - 1];
        wait_idx(s_last + FRAME + 5);
        for (int n = 0; n < n_rand; n++) check_frame(sv[n], dv[n]);
        chk("rand_pops", count_ones(2, ev[0], s_last + FRAME + 5), n_rand);
        chk("rand_empty", int'(fifo_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
